// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Sits between the fetch unit and decode. Fetched words are latched in an
//   IF/ID register (IR). BRANCH, JAL and JALR in the IR are decoded here, and
//   branch conditions are resolved from register-file data. Taken control flow
//   raises a one-cycle redirect pulse back to fetch, and the wrong-path words
//   already in flight are then squashed.
//
//   Optional feature: define REDIRECT_CNT_EN to build the 32-bit redirect
//   counter. Without it, redirect_cnt_o is tied to zero.
//
// Parameters
//   FLUSH_DEPTH  number of cycles flush_o stays high after a redirect (1..7)
//   XLEN         data/address width (>= 32)
//
// Ports
//   clk_i, rst_ni          clock (posedge) and async active-low reset
//   instr_valid_i          PC_instr_i/RD_i carry a fetched word this cycle
//   PC_instr_i, RD_i       fetched PC and instruction word
//   rs1_data_i, rs2_data_i regfile read data for rs1_addr_o/rs2_addr_o
//   rs1_addr_o, rs2_addr_o IR[19:15], IR[24:20]
//   BE_o, UJE_o, JALRE_o   one-cycle branch/JAL/JALR redirect pulses
//   immed_o, R1_o          redirect offset and rs1 value (held between pulses)
//   id_valid_o             IR holds a valid, non-squashed word
//   id_instr_o, id_pc_o    IR instruction and PC
//   flush_o                high while wrong-path words are discarded
//   illegal_o              BRANCH with funct3 010/011 in a valid IR
//   redirect_cnt_o         number of redirects since reset
module fetch_redirect_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] PC_instr_i,
  input  logic [31:0]     RD_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            BE_o,
  output logic            UJE_o,
  output logic            JALRE_o,
  output logic [XLEN-1:0] immed_o,
  output logic [XLEN-1:0] R1_o,
  output logic            id_valid_o,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            flush_o,
  output logic            illegal_o,
  output logic [31:0]     redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REDIR,
    ST_FLUSH
  } state_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              ir_valid_q;
  logic [31:0]       ir_instr_q;
  logic [XLEN-1:0]   ir_pc_q;

  logic              be_q, uje_q, jalre_q;
  logic [XLEN-1:0]   immed_q, r1_q;

  // decode results
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              br_cond;
  logic              take_be, take_uje, take_jalre, taken;
  logic              illegal;
  logic              flush;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_ext;

  assign opcode  = ir_instr_q[6:0];
  assign funct3  = ir_instr_q[14:12];
  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    br_cond    = 1'b0;
    take_be    = 1'b0;
    take_uje   = 1'b0;
    take_jalre = 1'b0;
    illegal    = 1'b0;
    imm32      = '0;
    if (ir_valid_q) begin
      unique case (opcode)
        OPC_BRANCH: begin
          imm32 = {{19{ir_instr_q[31]}}, ir_instr_q[31], ir_instr_q[7],
                   ir_instr_q[30:25], ir_instr_q[11:8], 1'b0};
          case (funct3)
            3'b000:  br_cond = (rs1_data_i == rs2_data_i);
            3'b001:  br_cond = (rs1_data_i != rs2_data_i);
            3'b100:  br_cond = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            3'b101:  br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  br_cond = (rs1_data_i <  rs2_data_i);
            3'b111:  br_cond = (rs1_data_i >= rs2_data_i);
            default: illegal = 1'b1;  // 010/011: reported, never taken
          endcase
          take_be = br_cond;
        end
        OPC_JAL: begin
          imm32 = {{11{ir_instr_q[31]}}, ir_instr_q[31], ir_instr_q[19:12],
                   ir_instr_q[20], ir_instr_q[30:21], 1'b0};
          take_uje = 1'b1;
        end
        OPC_JALR: begin
          imm32 = {{20{ir_instr_q[31]}}, ir_instr_q[31:20]};
          take_jalre = (funct3 == 3'b000);
        end
        default: ;
      endcase
    end
  end

  assign taken = take_be | take_uje | take_jalre;

  // Flush lasts FLUSH_DEPTH cycles in total: one REDIR cycle followed by
  // FLUSH_DEPTH-1 FLUSH cycles; FLUSH exits on the edge where cnt reaches 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (taken) state_d = ST_REDIR;
      end
      ST_REDIR: begin
        flush = 1'b1;
        if (FLUSH_DEPTH <= 1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_DEPTH - 1);
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // IR: the word arriving alongside a taken redirect is wrong-path, so it is
  // dropped together with everything arriving during REDIR/FLUSH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
    end else if (state_q == ST_RUN && !taken && instr_valid_i) begin
      ir_valid_q <= 1'b1;
      ir_instr_q <= RD_i;
      ir_pc_q    <= PC_instr_i;
    end else begin
      ir_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      be_q    <= 1'b0;
      uje_q   <= 1'b0;
      jalre_q <= 1'b0;
      immed_q <= '0;
      r1_q    <= '0;
    end else begin
      be_q    <= (state_q == ST_RUN) && take_be;
      uje_q   <= (state_q == ST_RUN) && take_uje;
      jalre_q <= (state_q == ST_RUN) && take_jalre;
      if (state_q == ST_RUN && taken) begin
        immed_q <= imm_ext;
        r1_q    <= rs1_data_i;
      end
    end
  end

`ifdef REDIRECT_CNT_EN
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_cnt_q <= '0;
    end else if (state_q == ST_RUN && taken) begin
      redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
`else
  assign redirect_cnt_o = '0;
`endif

  assign rs1_addr_o = ir_instr_q[19:15];
  assign rs2_addr_o = ir_instr_q[24:20];
  assign BE_o       = be_q;
  assign UJE_o      = uje_q;
  assign JALRE_o    = jalre_q;
  assign immed_o    = immed_q;
  assign R1_o       = r1_q;
  assign id_valid_o = ir_valid_q;
  assign id_instr_o = ir_instr_q;
  assign id_pc_o    = ir_pc_q;
  assign flush_o    = flush;
  assign illegal_o  = illegal;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl (FLUSH_DEPTH=2, XLEN=32).
// The register file is modelled as a small array read through the DUT's
// rs1/rs2 address outputs.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic [31:0] rd_in;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        be, uje, jalre;
  logic [31:0] immed, r1;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic        flush, illegal;
  logic [31:0] redirect_cnt;

  logic [31:0] regs [32];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ   = 32'h0020_8863;  // beq  x1,x2,+16
  localparam logic [31:0] BLT   = 32'h0020_C863;  // blt  x1,x2,+16
  localparam logic [31:0] BLTU  = 32'h0020_E863;  // bltu x1,x2,+16
  localparam logic [31:0] BILL  = 32'h0020_A863;  // BRANCH funct3=010
  localparam logic [31:0] JAL   = 32'hFF9F_F06F;  // jal  x0,-8 (rs1 field = x31)
  localparam logic [31:0] JALR  = 32'h0042_8067;  // jalr x0,4(x5)

  always #5 clk = ~clk;

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  fetch_redirect_ctrl #(
    .FLUSH_DEPTH(2),
    .XLEN(32)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_valid_i  (instr_valid),
    .PC_instr_i     (pc_in),
    .RD_i           (rd_in),
    .rs1_data_i     (rs1_data),
    .rs2_data_i     (rs2_data),
    .rs1_addr_o     (rs1_addr),
    .rs2_addr_o     (rs2_addr),
    .BE_o           (be),
    .UJE_o          (uje),
    .JALRE_o        (jalre),
    .immed_o        (immed),
    .R1_o           (r1),
    .id_valid_o     (id_valid),
    .id_instr_o     (id_instr),
    .id_pc_o        (id_pc),
    .flush_o        (flush),
    .illegal_o      (illegal),
    .redirect_cnt_o (redirect_cnt)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    instr_valid = v;
    pc_in       = pc;
    rd_in       = instr;
  endtask

  // Present a taken control-flow word, then walk IR -> REDIR -> FLUSH -> RUN
  // while the fetch side keeps offering (wrong-path) valid words.
  task automatic run_taken(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic e_be, input logic e_uje, input logic e_jalre,
                           input logic [31:0] e_imm, input logic [31:0] e_r1);
    put(1'b1, pc, instr);
    step();
    chk1 ({tag, "_ir_valid"}, id_valid, 1'b1);
    chk32({tag, "_ir_instr"}, id_instr, instr);
    chk1 ({tag, "_ir_flush"}, flush, 1'b0);
    put(1'b1, pc + 32'd4, NOP);
    step();
    chk1 ({tag, "_be"},    be,    e_be);
    chk1 ({tag, "_uje"},   uje,   e_uje);
    chk1 ({tag, "_jalre"}, jalre, e_jalre);
    chk32({tag, "_immed"}, immed, e_imm);
    chk32({tag, "_r1"},    r1,    e_r1);
    chk1 ({tag, "_redir_flush"}, flush, 1'b1);
    chk1 ({tag, "_redir_idv"},   id_valid, 1'b0);
    put(1'b1, pc + 32'd8, NOP);
    step();
    chk1 ({tag, "_fl_flush"}, flush, 1'b1);
    chk1 ({tag, "_fl_pulse"}, be | uje | jalre, 1'b0);
    chk1 ({tag, "_fl_idv"},   id_valid, 1'b0);
    chk32({tag, "_fl_immed"}, immed, e_imm);
    put(1'b1, pc + 32'd12, NOP);
    step();
    chk1 ({tag, "_run_flush"}, flush, 1'b0);
    chk1 ({tag, "_run_idv"},   id_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] cnt_exp5, cnt_exp3;
`ifdef REDIRECT_CNT_EN
    cnt_exp5 = 32'd5;
    cnt_exp3 = 32'd3;
`else
    cnt_exp5 = 32'd0;
    cnt_exp3 = 32'd0;
`endif
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'd5;
    regs[2] = 32'd5;
    regs[5] = 32'h0000_2000;

    // 1: reset held with a valid word on the input
    rst_n = 1'b0;
    put(1'b1, 32'h0000_00FC, NOP);
    step();
    step();
    chk1 ("rst_idv",   id_valid, 1'b0);
    chk32("rst_instr", id_instr, 32'h0);
    chk32("rst_pc",    id_pc, 32'h0);
    chk1 ("rst_flush", flush, 1'b0);
    chk1 ("rst_pulse", be | uje | jalre, 1'b0);
    chk32("rst_immed", immed, 32'h0);
    chk32("rst_r1",    r1, 32'h0);
    chk1 ("rst_ill",   illegal, 1'b0);
    chk32("rst_cnt",   redirect_cnt, 32'h0);
    rst_n = 1'b1;
    step();
    chk1 ("first_idv", id_valid, 1'b1);
    chk32("first_pc",  id_pc, 32'h0000_00FC);

    // 2: beq x1,x2,+16 with x1 == x2
    run_taken("beq", 32'h0000_0100, BEQ, 1'b1, 1'b0, 1'b0, 32'd16, 32'd5);
    put(1'b1, 32'h0000_0110, NOP);
    step();
    chk1 ("beq_tgt_idv", id_valid, 1'b1);
    chk32("beq_tgt_pc",  id_pc, 32'h0000_0110);

    // 3: signed vs unsigned compare of 0xFFFFFFFF against 1
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'd1;
    run_taken("blt", 32'h0000_0200, BLT, 1'b1, 1'b0, 1'b0, 32'd16, 32'hFFFF_FFFF);
    put(1'b1, 32'h0000_0220, BLTU);
    step();
    chk1 ("bltu_ir_idv", id_valid, 1'b1);
    put(1'b1, 32'h0000_0224, NOP);
    step();
    chk1 ("bltu_be",    be, 1'b0);
    chk1 ("bltu_flush", flush, 1'b0);
    chk1 ("bltu_idv",   id_valid, 1'b1);
    chk32("bltu_pc",    id_pc, 32'h0000_0224);
    chk32("bltu_immed_hold", immed, 32'd16);

    // 4: JAL -8, JALR x0,4(x5)
    run_taken("jal",  32'h0000_0300, JAL,  1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    run_taken("jalr", 32'h0000_0340, JALR, 1'b0, 1'b0, 1'b1, 32'd4, 32'h0000_2000);

    // 5a: BRANCH funct3=010 flags illegal, not taken, word still passes on
    put(1'b1, 32'h0000_0400, BILL);
    step();
    chk1 ("ill_pulse", illegal, 1'b1);
    chk1 ("ill_idv",   id_valid, 1'b1);
    put(1'b1, 32'h0000_0404, NOP);
    step();
    chk1 ("ill_clear", illegal, 1'b0);
    chk1 ("ill_be",    be, 1'b0);
    chk1 ("ill_flush", flush, 1'b0);
    chk32("ill_next_pc", id_pc, 32'h0000_0404);

    // 5b: reset asserted in the middle of FLUSH
    regs[1] = 32'd5;
    regs[2] = 32'd5;
    put(1'b1, 32'h0000_0500, BEQ);
    step();
    put(1'b0, 32'h0, NOP);
    step();
    chk1 ("rb_be", be, 1'b1);
    step();
    chk1 ("rb_in_flush", flush, 1'b1);
    chk32("rb_cnt5", redirect_cnt, cnt_exp5);
    #1 rst_n = 1'b0;
    #1;
    chk1 ("rb_async_flush", flush, 1'b0);
    chk1 ("rb_async_idv",   id_valid, 1'b0);
    chk32("rb_async_cnt",   redirect_cnt, 32'h0);
    #1 rst_n = 1'b1;
    step();
    chk1 ("rb_run_flush", flush, 1'b0);
    chk1 ("rb_run_be",    be, 1'b0);
    put(1'b1, 32'h0000_0600, NOP);
    step();
    chk1 ("rb_stream_idv", id_valid, 1'b1);
    chk32("rb_stream_pc",  id_pc, 32'h0000_0600);

    // 6: three redirects after reset
    run_taken("c1", 32'h0000_0700, BEQ,  1'b1, 1'b0, 1'b0, 32'd16, 32'd5);
    run_taken("c2", 32'h0000_0740, JAL,  1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    run_taken("c3", 32'h0000_0780, JALR, 1'b0, 1'b0, 1'b1, 32'd4, 32'h0000_2000);
    chk32("cnt3", redirect_cnt, cnt_exp3);

    put(1'b0, 32'h0, NOP);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
